// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem address/data, execute redirect and the IF/ID handshake to decode.
// master = fetch unit, slave = the imem/execute/decode side.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        fetch_fault;

  modport master (
    output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, fetch_fault,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, fetch_fault,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, registers imem output into the IF/ID slot.
// Define FETCH_MISALIGN_TRAP_EN to fault and halt on a misaligned redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;
`else
  typedef enum logic [1:0] {StBoot, StRun} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_plus4_q;
  logic [31:0] id_instr_q;
  logic        adv;
  logic [31:0] redirect_tgt;

  assign adv = !id_valid_q || bus.id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  logic misaligned;
  assign misaligned      = bus.redirect_pc[1:0] != 2'b00;
  assign redirect_tgt    = bus.redirect_pc;
  assign bus.fetch_fault = fault_q;
`else
  // Without the trap, misaligned targets are silently forced onto a word boundary.
  assign redirect_tgt    = bus.redirect_pc & 32'hFFFF_FFFC;
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_instr    = id_instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
      id_instr_q    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StBoot, StRun: begin
          if (bus.redirect_valid) begin
            // Slot is flushed even if decode consumed it this cycle; target fetched next cycle.
            pc_q       <= redirect_tgt;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            state_q    <= StRun;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              fault_q <= 1'b1;
              state_q <= StHalt;
            end
`endif
          end else if (state_q == StRun) begin
            if (adv) begin
              id_pc_q       <= pc_q;
              id_pc_plus4_q <= pc_q + 32'd4;
              id_instr_q    <= bus.imem_instr;
              id_valid_q    <= 1'b1;
              pc_q          <= pc_q + 32'd4;
            end
          end else begin
            state_q <= StRun;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
